// File: rtl/inst_encoder.sv
// Instruction encoder: range-checks the immediate for the opcode's format, packs an
// RV32I word and streams valid words into instruction memory through a 2-stage pipe.
module inst_encoder #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] load_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J} fmt_e;

    fmt_e              fmt_d;
    logic              imm_ok_d;

    logic              rdy_q;
    logic              s1_vld_q, s1_err_q;
    fmt_e              s1_fmt_q;
    logic [6:0]        s1_op_q, s1_f7_q;
    logic [4:0]        s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]        s1_f3_q;
    logic [20:0]       s1_imm_q;
    logic              s2_vld_q;
    logic [ADDR_W-1:0] addr_q, ptr_q, ptr_d;
    logic [31:0]       wdata_q, word_d;
    logic              err_pulse_q;
    logic [7:0]        err_cnt_q;

    logic s2_load, s1_adv, accept, s1_good, s1_rej, write;

    always_comb begin
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111: fmt_d = FMT_I;
            7'b0100011:                         fmt_d = FMT_S;
            7'b1100011:                         fmt_d = FMT_B;
            7'b1101111:                         fmt_d = FMT_J;
            default:                            fmt_d = FMT_R;
        endcase
    end

    always_comb begin
        case (fmt_d)
            FMT_I, FMT_S: imm_ok_d = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
            FMT_B:        imm_ok_d = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
            FMT_J:        imm_ok_d = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];
            default:      imm_ok_d = 1'b1;
        endcase
    end

    always_comb begin
        case (s1_fmt_q)
            FMT_I:   word_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            FMT_S:   word_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
            FMT_B:   word_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                               s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
            FMT_J:   word_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                               s1_rd_q, s1_op_q};
            default: word_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        endcase
    end

    // A rejected bundle in S1 is a bubble: it always leaves and never feeds S2.
    assign s2_load  = !s2_vld_q || out_ready;
    assign s1_adv   = s2_load || !s1_vld_q || s1_err_q;
    assign in_ready = rdy_q && s1_adv;
    assign accept   = in_valid && in_ready;
    assign s1_good  = s1_vld_q && !s1_err_q;
    assign s1_rej   = s1_vld_q && s1_err_q;
    assign write    = s2_vld_q && out_ready;

    // The next pointer is also the address a word takes as it enters S2.
    always_comb begin
        ptr_d = ptr_q;
        if (load_addr)  ptr_d = load_val;
        else if (write) ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_fmt_q    <= FMT_R;
            s1_op_q     <= '0;
            s1_f7_q     <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_f3_q     <= '0;
            s1_imm_q    <= '0;
            s2_vld_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ptr_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (s1_adv) begin
                s1_vld_q <= accept;
                if (accept) begin
                    s1_err_q <= !imm_ok_d;
                    s1_fmt_q <= fmt_d;
                    s1_op_q  <= opcode;
                    s1_f7_q  <= funct7;
                    s1_rd_q  <= rd;
                    s1_rs1_q <= rs1;
                    s1_rs2_q <= rs2;
                    s1_f3_q  <= funct3;
                    s1_imm_q <= imm[20:0];
                end
            end
            if (s2_load) begin
                s2_vld_q <= s1_good;
                if (s1_good) begin
                    addr_q  <= ptr_d;
                    wdata_q <= word_d;
                end
            end
            ptr_q       <= ptr_d;
            err_pulse_q <= s1_rej;
            if (s1_rej && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign out_valid = s2_vld_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors for packing, errors, stalls and pointer
// behaviour, then a randomized stream checked by decoding the written words.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        load_addr;
    logic [8:0]  load_val;
    logic        out_valid, out_ready;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        err_pulse;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        int         imm;
    } bundle_t;

    inst_encoder #(.ADDR_W(9)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .load_addr(load_addr), .load_val(load_val), .out_valid(out_valid),
        .out_ready(out_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 0=R 1=I 2=S 3=B 4=J
    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 1;
            7'b0100011: return 2;
            7'b1100011: return 3;
            7'b1101111: return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [6:0] op, input int im);
        case (fmt_of(op))
            1, 2:    return im >= -2048 && im <= 2047;
            3:       return im >= -4096 && im <= 4094 && (im % 2) == 0;
            4:       return im >= -1048576 && im <= 1048574 && (im % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    // Immediate generator as the decode stage sees it.
    function automatic int dec_imm(input logic [31:0] w, input int f);
        case (f)
            1:       return int'($signed(w[31:20]));
            2:       return int'($signed({w[31:25], w[11:7]}));
            3:       return int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            4:       return int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: return 0;
        endcase
    endfunction

    function automatic bit word_matches(input bundle_t e, input logic [31:0] w);
        int f;
        f = fmt_of(e.op);
        if (w[6:0] != e.op) return 1'b0;
        if (f == 0) return w == {e.f7, e.rs2, e.rs1, e.f3, e.rd, e.op};
        if (dec_imm(w, f) != e.imm) return 1'b0;
        if ((f == 1 || f == 4) && w[11:7] != e.rd) return 1'b0;
        if ((f == 1 || f == 2 || f == 3) && (w[19:15] != e.rs1 || w[14:12] != e.f3)) return 1'b0;
        if ((f == 2 || f == 3) && w[24:20] != e.rs2) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input int im);
        in_valid = 1'b1; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3;
        funct7 = 7'h00; imm = im;
    endtask

    task automatic load_ptr(input logic [8:0] v);
        load_addr = 1'b1; load_val = v;
        step();
        load_addr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; load_addr = 1'b0; load_val = '0; out_ready = 1'b1;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse: got %b want 0", err_pulse); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", err_count); end
        reset = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, -1);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL addi_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'hFFF00093) begin errors++; $display("FAIL addi_word: got %h want FFF00093", mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_done: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        load_ptr(9'd0);
        drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 8);
        step();
        drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 8);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd0 || mem_wdata !== 32'h0020A423) begin
            errors++; $display("FAIL b2b_sw: got v=%b @%0d %h want v=1 @0 0020A423", out_valid, mem_addr, mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd1 || mem_wdata !== 32'h008000EF) begin
            errors++; $display("FAIL b2b_jal: got v=%b @%0d %h want v=1 @1 008000EF", out_valid, mem_addr, mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b want 0", out_valid); end
    endtask

    task automatic test_branch_error();
        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -4);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd2 || mem_wdata !== 32'hFE208EE3) begin
            errors++; $display("FAIL beq_word: got v=%b @%0d %h want v=1 @2 FE208EE3", out_valid, mem_addr, mem_wdata); end
        step();
        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -3);
        step();
        in_valid = 1'b0;
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL odd_early: got %b want 0", err_pulse); end
        step();
        checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin
            errors++; $display("FAIL odd_pulse: got p=%b c=%0d want p=1 c=1", err_pulse, err_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL odd_nowrite: got %b want 0", out_valid); end
        step();
        checks++; if (err_pulse !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL odd_after: got p=%b v=%b want p=0 v=0", err_pulse, out_valid); end
    endtask

    task automatic test_range();
        bit low_seen;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 2048);
        step();
        drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 1048576);
        step();
        in_valid = 1'b0;
        step(); step();
        checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL range_count: got %0d want 3", err_count); end
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 2047);
        step();
        drive(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, -1048576);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd3 || mem_wdata !== 32'h7FF00093) begin
            errors++; $display("FAIL edge_addi: got v=%b @%0d %h want v=1 @3 7FF00093", out_valid, mem_addr, mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd4 || mem_wdata !== 32'h8000006F) begin
            errors++; $display("FAIL edge_jal: got v=%b @%0d %h want v=1 @4 8000006F", out_valid, mem_addr, mem_wdata); end
        step();
        low_seen = 1'b0;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 4096);
        for (int i = 0; i < 300; i++) begin
            if (in_ready !== 1'b1) low_seen = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        checks++; if (low_seen) begin errors++; $display("FAIL sat_ready: got in_ready=0 during rejects want 1"); end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", err_count); end
    endtask

    task automatic test_stall();
        load_ptr(9'd100);
        out_ready = 1'b0;
        drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 5);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy0: got %b want 1", in_ready); end
        step();
        drive(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 6);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy1: got %b want 1", in_ready); end
        step();
        drive(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || mem_addr !== 9'd100 || mem_wdata !== 32'h00500193) begin
                errors++; $display("FAIL stall_hold%0d: got r=%b v=%b @%0d %h want r=0 v=1 @100 00500193",
                                   i, in_ready, out_valid, mem_addr, mem_wdata); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd101 || mem_wdata !== 32'h00600213) begin
            errors++; $display("FAIL stall_w1: got v=%b @%0d %h want v=1 @101 00600213", out_valid, mem_addr, mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd102 || mem_wdata !== 32'h00700293) begin
            errors++; $display("FAIL stall_w2: got v=%b @%0d %h want v=1 @102 00700293", out_valid, mem_addr, mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_done: got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        load_ptr(9'd511);
        drive(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 1);
        step();
        drive(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 2);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd511 || mem_wdata !== 32'h00100313) begin
            errors++; $display("FAIL wrap_hi: got v=%b @%0d %h want v=1 @511 00100313", out_valid, mem_addr, mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd0 || mem_wdata !== 32'h00200393) begin
            errors++; $display("FAIL wrap_lo: got v=%b @%0d %h want v=1 @0 00200393", out_valid, mem_addr, mem_wdata); end
        step();
    endtask

    task automatic test_load_during_write();
        drive(7'b0010011, 5'd8, 5'd0, 5'd0, 3'd0, 3);
        step();
        in_valid = 1'b0;
        step();
        load_addr = 1'b1; load_val = 9'd200;
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd1 || mem_wdata !== 32'h00300413) begin
            errors++; $display("FAIL ld_old: got v=%b @%0d %h want v=1 @1 00300413", out_valid, mem_addr, mem_wdata); end
        step();
        load_addr = 1'b0;
        drive(7'b0010011, 5'd9, 5'd0, 5'd0, 3'd0, 4);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd200 || mem_wdata !== 32'h00400493) begin
            errors++; $display("FAIL ld_new: got v=%b @%0d %h want v=1 @200 00400493", out_valid, mem_addr, mem_wdata); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 5);
        step();
        drive(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 6);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", out_valid); end
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || mem_addr !== 9'd0 || mem_wdata !== 32'h0 || err_count !== 8'd0) begin
            errors++; $display("FAIL mid_rst: got v=%b @%0d %h c=%0d want v=0 @0 0 c=0",
                               out_valid, mem_addr, mem_wdata, err_count); end
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flush: got %b want 0", out_valid); end
        drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 5);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || mem_addr !== 9'd0 || mem_wdata !== 32'h00500193) begin
            errors++; $display("FAIL mid_ptr: got v=%b @%0d %h want v=1 @0 00500193", out_valid, mem_addr, mem_wdata); end
        step();
    endtask

    task automatic test_random();
        logic [6:0] ops [8] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110011, 7'b0110111};
        bundle_t q[$];
        bundle_t b, e;
        logic [8:0] mptr;
        int merr, f, n;
        bit rp1, rp2, rej;
        reset = 1'b1; in_valid = 1'b0; load_addr = 1'b0;
        step();
        reset = 1'b0;
        step();
        mptr = '0; merr = 0; rp1 = 1'b0; rp2 = 1'b0;
        n = 1500;
        for (int i = 0; i < n; i++) begin
            b.op = ops[$urandom_range(7)];
            b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
            b.f3 = 3'($urandom); b.f7 = 7'($urandom);
            f = fmt_of(b.op);
            case (f)
                1, 2:    b.imm = int'($urandom_range(4400)) - 2200;
                3:       b.imm = int'($urandom_range(8600)) - 4300;
                4:       b.imm = int'($urandom_range(2200000)) - 1100000;
                default: b.imm = int'($urandom);
            endcase
            in_valid = (i < n - 20) ? ($urandom_range(3) != 0) : 1'b0;
            opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
            funct3 = b.f3; funct7 = b.f7; imm = b.imm;
            out_ready = (i < n - 20) ? ($urandom_range(3) != 0) : 1'b1;
            load_addr = (q.size() == 0 && i < n - 20 && $urandom_range(15) == 0);
            load_val = 9'($urandom);
            #1;
            checks++; if (err_pulse !== rp2) begin errors++; $display("FAIL rnd_pulse cyc %0d: got %b want %b", i, err_pulse, rp2); end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra cyc %0d: got write %h @%0d want none", i, mem_wdata, mem_addr);
                end else begin
                    e = q.pop_front();
                    if (mem_addr !== mptr || !word_matches(e, mem_wdata)) begin
                        errors++; $display("FAIL rnd_write cyc %0d: got %h @%0d want op=%b imm=%0d @%0d",
                                           i, mem_wdata, mem_addr, e.op, e.imm, mptr);
                    end
                end
                mptr = mptr + 9'd1;
            end
            if (load_addr) mptr = load_val;
            rej = 1'b0;
            if (in_valid && in_ready === 1'b1) begin
                if (legal(b.op, b.imm)) q.push_back(b);
                else begin
                    rej = 1'b1;
                    if (merr < 255) merr++;
                end
            end
            rp2 = rp1; rp1 = rej;
            step();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d words unwritten want 0", q.size()); end
        checks++; if (err_count !== 8'(merr)) begin errors++; $display("FAIL rnd_count: got %0d want %0d", err_count, merr); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_branch_error();
        test_range();
        test_stall();
        test_wrap();
        test_load_during_write();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
